// File: rtl/sched_pkg.sv
// ----------------------------------------------------------------------------
// sched_pkg
// Shared types and default sizing for the round-robin unit scheduler.
//   sched_state_t : scheduler FSM state encoding
//   DEF_*         : default parameter values for N_REQ / OP_W / TIMEOUT
// ----------------------------------------------------------------------------
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam int unsigned DEF_N_REQ   = 3;
    localparam int unsigned DEF_OP_W    = 32;
    localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Searches req starting at ptr and
// wrapping modulo N_REQ; the first set bit wins.
// Ports:
//   req    in  N_REQ          request vector
//   ptr    in  $clog2(N_REQ)  highest-priority index
//   any    out 1              at least one request is set
//   winner out $clog2(N_REQ)  index of the winning request (0 when !any)
// ----------------------------------------------------------------------------
module rr_pick import sched_pkg::*; #(
    parameter int unsigned N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] winner
);

    localparam int unsigned IW = $clog2(N_REQ);

    // Upper copy of the request vector supplies the wrapped-around candidates,
    // so no modulo arithmetic is needed and non-power-of-2 N_REQ works.
    logic [2*N_REQ-1:0] w_req2;
    logic [2*N_REQ-1:0] w_masked;
    logic               w_found;

    always_comb begin
        w_req2 = {req, req};
        for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
            w_masked[i] = w_req2[i] && (i >= 32'(ptr));
        end
    end

    always_comb begin
        any     = |req;
        winner  = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
            if (!w_found && w_masked[i]) begin
                w_found = 1'b1;
                winner  = (i >= N_REQ) ? IW'(i - N_REQ) : IW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_unit_scheduler.sv
// ----------------------------------------------------------------------------
// rr_unit_scheduler
// Shares one multi-cycle execution unit between N_REQ requesters using
// round-robin arbitration. One op in flight; a watchdog forces an error
// response when the unit does not answer within TIMEOUT WAIT cycles.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-requester request (held until req_ready)
//   req_data      packed operands, requester i at [i*OP_W +: OP_W]
//   req_ready     one-hot accept pulse (ISSUE)
//   unit_start    start pulse to the unit (ISSUE)
//   unit_data     latched operand for the unit
//   unit_done     unit completion strobe, unit_result valid with it
//   rsp_valid     one-hot response pulse (RESP)
//   rsp_data      result, rsp_err = 1 on timeout
//   grant_id      current/last winner
//   busy          state != IDLE
//   err_spurious  sticky: unit_done seen outside WAIT
// ----------------------------------------------------------------------------
module rr_unit_scheduler import sched_pkg::*; #(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned OP_W    = DEF_OP_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*OP_W-1:0]    req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     unit_start,
    output logic [OP_W-1:0]          unit_data,
    input  logic                     unit_done,
    input  logic [OP_W-1:0]          unit_result,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [OP_W-1:0]          rsp_data,
    output logic                     rsp_err,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     err_spurious
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    sched_state_t   r_state;
    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  r_grant;
    logic [OP_W-1:0] r_unit_data;
    logic [OP_W-1:0] r_rsp_data;
    logic           r_rsp_err;
    logic           r_err_spurious;
    logic [WW-1:0]  r_wdog;

    logic           w_any;
    logic [IW-1:0]  w_winner;
    logic [N_REQ-1:0] w_grant_oh;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (r_ptr),
        .any    (w_any),
        .winner (w_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_grant        <= '0;
            r_unit_data    <= '0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_err_spurious <= 1'b0;
            r_wdog         <= '0;
        end else begin
            if (unit_done && (r_state != WAIT)) begin
                r_err_spurious <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_winner;
                        r_unit_data <= req_data[w_winner*OP_W +: OP_W];
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Pointer moves past the winner only once the op is accepted.
                    r_ptr   <= (r_grant == IW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
                    r_wdog  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // done takes priority over a coincident timeout
                    if (unit_done) begin
                        r_rsp_data <= unit_result;
                        r_rsp_err  <= 1'b0;
                        r_state    <= RESP;
                    end else if (r_wdog == WW'(TIMEOUT - 1)) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_grant_oh[i] = (r_grant == IW'(i));
        end
    end

    // Pulse outputs are decoded from registered state only.
    assign req_ready    = (r_state == ISSUE) ? w_grant_oh : '0;
    assign unit_start   = (r_state == ISSUE);
    assign rsp_valid    = (r_state == RESP) ? w_grant_oh : '0;
    assign unit_data    = r_unit_data;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign grant_id     = r_grant;
    assign busy         = (r_state != IDLE);
    assign err_spurious = r_err_spurious;

endmodule

// File: tb/tb_rr_unit_scheduler.sv
// ----------------------------------------------------------------------------
// tb_rr_unit_scheduler
// Directed bench for rr_unit_scheduler with N_REQ=3, OP_W=32, TIMEOUT=16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_rr_unit_scheduler;

    localparam int unsigned N_REQ   = 3;
    localparam int unsigned OP_W    = 32;
    localparam int unsigned TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*OP_W-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  unit_start;
    logic [OP_W-1:0]       unit_data;
    logic                  unit_done;
    logic [OP_W-1:0]       unit_result;
    logic [N_REQ-1:0]      rsp_valid;
    logic [OP_W-1:0]       rsp_data;
    logic                  rsp_err;
    logic [1:0]            grant_id;
    logic                  busy;
    logic                  err_spurious;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_unit_scheduler #(
        .N_REQ   (N_REQ),
        .OP_W    (OP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .unit_start   (unit_start),
        .unit_data    (unit_data),
        .unit_done    (unit_done),
        .unit_result  (unit_result),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .grant_id     (grant_id),
        .busy         (busy),
        .err_spurious (err_spurious)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts in IDLE with requests applied; ends back in IDLE.
    // lat = cycles from unit_start to the cycle unit_done is high (>= 1).
    task automatic run_op(input logic [1:0] gid, input logic [31:0] opnd,
                          input int lat, input logic [31:0] res);
        logic [2:0] oh;
        oh = 3'b001 << gid;
        tick();
        check("issue.start", 64'(unit_start), 64'd1);
        check("issue.ready", 64'(req_ready), 64'(oh));
        check("issue.gid", 64'(grant_id), 64'(gid));
        check("issue.data", 64'(unit_data), 64'(opnd));
        tick();
        for (int k = 1; k < lat; k++) begin
            tick();
        end
        check("wait.start", 64'(unit_start), 64'd0);
        check("wait.rsp", 64'(rsp_valid), 64'd0);
        check("wait.busy", 64'(busy), 64'd1);
        unit_done   = 1'b1;
        unit_result = res;
        tick();
        unit_done   = 1'b0;
        check("resp.valid", 64'(rsp_valid), 64'(oh));
        check("resp.data", 64'(rsp_data), 64'(res));
        check("resp.err", 64'(rsp_err), 64'd0);
        tick();
        check("idle.rsp", 64'(rsp_valid), 64'd0);
        check("idle.busy", 64'(busy), 64'd0);
    endtask

    initial begin
        // reset with noise on the inputs
        rst         = 1'b1;
        req_valid   = 3'($urandom);
        unit_done   = 1'($urandom);
        unit_result = $urandom;
        req_data    = '0;
        req_data[0*OP_W +: OP_W] = 32'h11;
        req_data[1*OP_W +: OP_W] = 32'h22;
        req_data[2*OP_W +: OP_W] = 32'h33;
        tick();
        tick();
        check("rst.ready", 64'(req_ready), 64'd0);
        check("rst.start", 64'(unit_start), 64'd0);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.rsp_err", 64'(rsp_err), 64'd0);
        check("rst.rsp_data", 64'(rsp_data), 64'd0);
        check("rst.unit_data", 64'(unit_data), 64'd0);
        check("rst.gid", 64'(grant_id), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.spur", 64'(err_spurious), 64'd0);

        // rotation with all three requesting, 1-cycle unit latency
        rst       = 1'b0;
        unit_done = 1'b0;
        req_valid = 3'b111;
        run_op(2'd0, 32'h11, 1, 32'h100);
        run_op(2'd1, 32'h22, 1, 32'h101);
        run_op(2'd2, 32'h33, 1, 32'h102);
        run_op(2'd0, 32'h11, 1, 32'h103);
        run_op(2'd1, 32'h22, 1, 32'h104);

        // single op, requester 1, done three cycles after start
        req_valid = 3'b010;
        req_data[1*OP_W +: OP_W] = 32'hA5;
        run_op(2'd1, 32'hA5, 3, 32'h5A);

        // serve 0 so ptr=1, then 3'b101: 2 wins before 0
        req_valid = 3'b001;
        run_op(2'd0, 32'h11, 2, 32'h77);
        req_valid = 3'b101;
        run_op(2'd2, 32'h33, 1, 32'h88);
        run_op(2'd0, 32'h11, 1, 32'h99);

        // done on the last watchdog cycle still wins over timeout
        req_valid = 3'b100;
        run_op(2'd2, 32'h33, TIMEOUT, 32'hDEAD);

        // timeout: ptr=0, requester 1 wins, unit never answers
        req_valid = 3'b010;
        tick();
        check("to.issue.gid", 64'(grant_id), 64'd1);
        check("to.issue.ready", 64'(req_ready), 64'b010);
        req_valid = 3'b000;
        for (int k = 0; k < TIMEOUT; k++) begin
            tick();
        end
        check("to.last_wait.rsp", 64'(rsp_valid), 64'd0);
        check("to.last_wait.busy", 64'(busy), 64'd1);
        tick();
        check("to.resp.valid", 64'(rsp_valid), 64'b010);
        check("to.resp.err", 64'(rsp_err), 64'd1);
        check("to.resp.data", 64'(rsp_data), 64'd0);
        tick();
        check("to.idle.busy", 64'(busy), 64'd0);
        check("to.idle.spur", 64'(err_spurious), 64'd0);

        // late done in IDLE is spurious and sticky
        unit_done   = 1'b1;
        unit_result = 32'h1234;
        tick();
        unit_done = 1'b0;
        check("spur.set", 64'(err_spurious), 64'd1);
        check("spur.rsp", 64'(rsp_valid), 64'd0);
        check("spur.busy", 64'(busy), 64'd0);
        tick();
        tick();
        check("spur.sticky", 64'(err_spurious), 64'd1);

        // reset during WAIT (ptr=2 -> requester 0 wins, ptr becomes 1)
        req_valid = 3'b001;
        tick();
        check("rmid.issue.gid", 64'(grant_id), 64'd0);
        req_valid = 3'b000;
        tick();
        tick();
        check("rmid.wait.busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid.busy", 64'(busy), 64'd0);
        check("rmid.gid", 64'(grant_id), 64'd0);
        check("rmid.unit_data", 64'(unit_data), 64'd0);
        check("rmid.spur", 64'(err_spurious), 64'd0);
        check("rmid.rsp", 64'(rsp_valid), 64'd0);
        unit_done   = 1'b1;
        unit_result = 32'hBEEF;
        tick();
        unit_done = 1'b0;
        check("rmid.late.rsp", 64'(rsp_valid), 64'd0);
        check("rmid.late.spur", 64'(err_spurious), 64'd1);
        req_valid = 3'b111;
        tick();
        check("rmid.regrant.gid", 64'(grant_id), 64'd0);
        check("rmid.regrant.ready", 64'(req_ready), 64'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_unit_scheduler.md
Name: rr_unit_scheduler

Overview:
Shares one multi-cycle execution unit (e.g. an FPU op pipe) between N_REQ requesters. Arbitration is round-robin with a rotating pointer. One operation is in flight at a time. The scheduler latches the winner's operand, issues a start pulse, waits for the unit's done, then routes the result back to the winner. It sits between requester front-ends and the shared unit, and includes a watchdog for units that never respond.

Parameters:
N_REQ, 3, number of requesters (≥2; need not be a power of 2)
OP_W, 32, operand/result width
TIMEOUT, 16, max WAIT cycles before forced error response (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester request; held with data until matching req_ready
req_data  in  N_REQ*OP_W  packed operands, requester i at [i*OP_W +: OP_W]
req_ready  out  N_REQ  one-hot, one-cycle accept pulse
unit_start  out  1  one-cycle start to shared unit
unit_data  out  OP_W  latched operand, stable from ISSUE until RESP
unit_done  in  1  unit completion strobe
unit_result  in  OP_W  valid when unit_done=1
rsp_valid  out  N_REQ  one-hot, one-cycle response pulse
rsp_data  out  OP_W  result; valid with rsp_valid
rsp_err  out  1  with rsp_valid: 1 = timeout
grant_id  out  $clog2(N_REQ)  index of current/last winner
busy  out  1  state != IDLE
err_spurious  out  1  sticky: unit_done seen outside WAIT

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; ptr=0; grant_id=0; unit_data=0; wdog=0; err_spurious=0. All pulse outputs (req_ready, unit_start, rsp_valid, rsp_err) are 0 and rsp_data=0. rst has priority over all events. rst mid-operation drops the in-flight op: no rsp_valid is produced, and the requester must re-request.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered or decoded from state. No combinational path from inputs to outputs.
- IDLE: if |req_valid, the winner is the first set bit searching ptr, ptr+1, ..., wrapping modulo N_REQ. At the clock edge: grant_id<=winner; unit_data<=req_data[winner]; state<=ISSUE. If no request, stay in IDLE.
- ISSUE (1 cycle): unit_start=1; req_ready[grant_id]=1; ptr<=(grant_id+1) mod N_REQ; wdog<=0; state<=WAIT.
- WAIT:
  - if unit_done: latch rsp_data<=unit_result, rsp_err<=0, state<=RESP.
  - else if wdog==TIMEOUT-1: rsp_data<=0, rsp_err<=1, state<=RESP.
  - else wdog++.
  - unit_done and timeout in the same cycle: done wins.
- RESP (1 cycle): rsp_valid[grant_id]=1. rsp_data and rsp_err are held. state<=IDLE.
- unit_done sampled in IDLE, ISSUE or RESP is ignored for data but sets err_spurious. err_spurious clears only on rst.
- Minimum unit latency is 1 (done in the first WAIT cycle). Minimum op period is 4 cycles: arbitrate, ISSUE, WAIT, RESP. No arbitration overlaps RESP.
- Fairness: a continuously requesting set of k requesters is served in strict rotating order. Max wait ≤ (N_REQ-1) ops.
- Requests deasserted before req_ready are a protocol violation. Data already latched is used.

Decomposition:
- Package sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP) as typedef sched_state_t; default constants for N_REQ/OP_W/TIMEOUT.
- Sub-module rr_pick: combinational rotating-priority encoder. Inputs req[N_REQ] and ptr. Outputs any and winner index. Implement via double-width request vector masking, so non-power-of-2 N_REQ is correct.
- The scheduler FSM, watchdog counter and datapath latches stay in rr_unit_scheduler.

Test Plan:
- Reset: rst=1 for 2 cycles with random req_valid/unit_done -> all outputs 0, busy=0, err_spurious=0. The first grant after rst deasserts goes to requester 0 when req_valid=3'b111.
- Single op: req_valid=3'b010, req_data[1]=0xA5, unit_done 3 cycles after unit_start with result 0x5A. Expected: req_ready=3'b010 and unit_start=1 in the same cycle; unit_data=0xA5; rsp_valid=3'b010, rsp_data=0x5A and rsp_err=0 the cycle after done.
- Rotation: req_valid=3'b111 held, done 1 cycle after each start -> grant order 0,1,2,0,1, with each op taking 4 cycles.
- Skip/wrap: ptr=1 (after serving 0), req_valid=3'b101 -> requester 2 wins, then 0. Requester 1 is never granted.
- Timeout: unit_done never asserted -> rsp_valid on the winner after exactly TIMEOUT=16 WAIT cycles, with rsp_err=1 and rsp_data=0. A late unit_done then pulsed in IDLE sets err_spurious=1, which stays set.
- Reset mid-op: rst=1 during WAIT, then unit_done arrives -> no rsp_valid, state IDLE, ptr=0. The post-reset done is treated as spurious.
